// File: rtl/elastic_pkg.sv
// ----------------------------------------------------------------------------
// elastic_pkg
// Shared types for the elastic pipeline:
//   pipe_mode_e   - stage flavour (MODE_FWD single-entry, MODE_SKID main+skid)
//   stage_state_e - occupancy state of a MODE_SKID stage
// ----------------------------------------------------------------------------
package elastic_pkg;

  typedef enum logic {
    MODE_FWD  = 1'b0,
    MODE_SKID = 1'b1
  } pipe_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/elastic_stage.sv
// ----------------------------------------------------------------------------
// elastic_stage
// One valid/ready register stage of the elastic pipeline.
//   clk, rst          - clock, asynchronous active-high reset
//   flush_i           - synchronous discard of the held beat(s)
//   valid_i/ready_o/data_i - upstream handshake and payload
//   valid_o/ready_i/data_o - downstream handshake and payload
// MODE_FWD : one entry, ready_o = ~valid | ready_i (combinational from ready_i).
// MODE_SKID: main + skid entry, ready_o = ~skid_valid from a register, so
//            ready_i never reaches ready_o combinationally.
// ----------------------------------------------------------------------------
module elastic_stage
  import elastic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter pipe_mode_e  MODE  = MODE_SKID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  if (MODE == MODE_FWD) begin : g_fwd
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             push_s;
    logic             pop_s;

    // Flush forces ready low so nothing is accepted in a discarding cycle.
    assign ready_o = (~valid_q | ready_i) & ~flush_i;
    assign push_s  = valid_i & ready_o;
    assign pop_s   = valid_q & ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Single-entry occupancy and payload register; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= {WIDTH{1'b0}};
      end else begin
        if (flush_i) begin
          valid_q <= 1'b0;
        end else if (push_s) begin
          valid_q <= 1'b1;
        end else if (pop_s) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= valid_q;
        end
        if (push_s) begin
          data_q <= data_i;
        end else begin
          data_q <= data_q;
        end
      end
    end
  end else begin : g_skid
    stage_state_e     state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push_s;
    logic             pop_s;

    // FULL means the skid entry is occupied; this is a pure register decode.
    assign ready_o = (state_q != FULL) & ~flush_i;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = main_q;
    assign push_s  = valid_i & ready_o;
    assign pop_s   = valid_o & ready_i;

    // Stage FSM: main entry always feeds the output, skid absorbs one extra beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= {WIDTH{1'b0}};
        skid_q  <= {WIDTH{1'b0}};
      end else if (flush_i) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (push_s) begin
              state_q <= BUSY;
              main_q  <= data_i;
            end
          end
          BUSY: begin
            if (push_s && !pop_s) begin
              state_q <= FULL;
              skid_q  <= data_i;
            end else if (!push_s && pop_s) begin
              state_q <= EMPTY;
            end else if (push_s && pop_s) begin
              main_q  <= data_i;
            end
          end
          FULL: begin
            // ready_o is low here, so only a pop can occur.
            if (pop_s) begin
              state_q <= BUSY;
              main_q  <= skid_q;
            end
          end
          default: begin
            state_q <= EMPTY;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// ----------------------------------------------------------------------------
// elastic_pipeline
// DEPTH chained elastic_stage instances with a beat-occupancy counter.
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - synchronous discard of all held beats
//   in_valid/in_ready/in_data    - upstream handshake and payload
//   out_valid/out_ready/out_data - downstream handshake and payload
//   count               - beats currently held (0 .. DEPTH or 2*DEPTH)
// ----------------------------------------------------------------------------
module elastic_pipeline
  import elastic_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter pipe_mode_e  MODE  = MODE_SKID,
  localparam int unsigned CW   = $clog2(2 * DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Element i is the link feeding stage i; element DEPTH is the output port.
  logic             vld_s [DEPTH+1];
  logic             rdy_s [DEPTH+1];
  logic [WIDTH-1:0] dat_s [DEPTH+1];

  logic          in_fire_s;
  logic          out_fire_s;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_q;

  assign vld_s[0]     = in_valid;
  assign dat_s[0]     = in_data;
  assign rdy_s[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    elastic_stage #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .valid_i (vld_s[i]),
      .ready_o (rdy_s[i]),
      .data_i  (dat_s[i]),
      .valid_o (vld_s[i+1]),
      .ready_i (rdy_s[i+1]),
      .data_o  (dat_s[i+1])
    );
  end

  // Keep upstream stalled for the whole time reset is asserted.
  assign in_ready   = rdy_s[0] & ~rst;
  assign out_valid  = vld_s[DEPTH];
  assign out_data   = dat_s[DEPTH];
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign count      = count_q;

  // Occupancy next-state: flush clears, simultaneous in/out transfers cancel.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = {CW{1'b0}};
    end else if (in_fire_s && !out_fire_s) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (!in_fire_s && out_fire_s) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipeline.sv
// ----------------------------------------------------------------------------
// tb_elastic_pipeline
// Directed bench for elastic_pipeline: a MODE_SKID DEPTH=4 instance (s_*) and
// a MODE_FWD DEPTH=2 instance (f_*) sharing clock and reset, followed by a
// scoreboarded random-handshake phase on both instances.
// ----------------------------------------------------------------------------
module tb_elastic_pipeline;
  import elastic_pkg::*;

  localparam int W  = 8;
  localparam int NR = 300;

  logic clk = 1'b0;
  logic rst;

  logic         s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [W-1:0] s_in_data, s_out_data;
  logic [3:0]   s_count;

  logic         f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
  logic [W-1:0] f_in_data, f_out_data;
  logic [2:0]   f_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(W), .DEPTH(4), .MODE(MODE_SKID)) u_skid4 (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .count(s_count)
  );

  elastic_pipeline #(.WIDTH(W), .DEPTH(2), .MODE(MODE_FWD)) u_fwd2 (
    .clk(clk), .rst(rst), .flush(f_flush),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
    .count(f_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty SKID pipeline must appear exactly 4 cycles later.
  task automatic lone_beat(input string tag, input logic [W-1:0] d);
    s_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_in_valid = (c == 0);
      s_in_data  = d;
      @(negedge clk);
      check({tag, "_out_valid"}, 32'(s_out_valid), 32'(c == 4));
      if (c == 4) check({tag, "_out_data"}, 32'(s_out_data), 32'(d));
      tick();
    end
    s_in_valid = 1'b0;
  endtask

  initial begin
    int acc, got, exp_cnt;
    logic ir0;
    logic [W-1:0] sq[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] s_cur, f_cur;
    logic s_acc, f_acc;
    int s_tx, s_rx, f_tx, f_rx;

    rst = 1'b1;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = 8'h00;
    f_flush = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0; f_in_data = 8'h00;

    // ---------------- reset state ----------------
    #2;
    check("rst_s_out_valid", 32'(s_out_valid), 32'd0);
    check("rst_s_count",     32'(s_count),     32'd0);
    check("rst_s_in_ready",  32'(s_in_ready),  32'd0);
    check("rst_f_in_ready",  32'(f_in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_s_in_ready", 32'(s_in_ready), 32'd1);
    check("rel_f_in_ready", 32'(f_in_ready), 32'd1);
    tick();

    // ---------------- SKID streaming, out_ready=1 ----------------
    s_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      s_in_valid = (c < 8);
      s_in_data  = W'(c + 1);
      @(negedge clk);
      exp_cnt = ((c < 8) ? c : 8) - ((c > 4) ? c - 4 : 0);
      check("stream_in_ready",  32'(s_in_ready),  32'd1);
      check("stream_out_valid", 32'(s_out_valid), 32'(c >= 4));
      if (c >= 4) check("stream_out_data", 32'(s_out_data), 32'(c - 3));
      check("stream_count", 32'(s_count), 32'(exp_cnt));
      tick();
    end
    s_in_valid = 1'b0;

    // ---------------- SKID fill with out_ready=0, then drain ----------------
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      s_in_data = W'(8'h10 + acc);
      @(negedge clk);
      if (s_in_ready) acc++;
      tick();
    end
    @(negedge clk);
    check("fill_accepted",  32'(acc),         32'd8);
    check("fill_in_ready",  32'(s_in_ready),  32'd0);
    check("fill_count",     32'(s_count),     32'd8);
    check("fill_out_data",  32'(s_out_data),  32'h10);
    tick();
    s_in_valid  = 1'b0;
    s_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 8; c++) begin
      @(negedge clk);
      if (s_out_valid) begin
        check("drain_data", 32'(s_out_data), 32'(8'h10 + got));
        got++;
      end
      tick();
    end
    check("drain_beats", 32'(got), 32'd8);
    @(negedge clk);
    check("drain_count", 32'(s_count), 32'd0);
    tick();

    // ---------------- SKID flush at count=5 ----------------
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_in_data = W'(8'h50 + c);
      tick();
    end
    s_flush   = 1'b1;
    s_in_data = 8'hEE;
    @(negedge clk);
    check("flush_count_before", 32'(s_count),    32'd5);
    check("flush_in_ready",     32'(s_in_ready), 32'd0);
    tick();
    s_flush    = 1'b0;
    s_in_valid = 1'b0;
    @(negedge clk);
    check("flush_count_after", 32'(s_count),     32'd0);
    check("flush_out_valid",   32'(s_out_valid), 32'd0);
    tick();
    lone_beat("flush_next", 8'hA5);

    // ---------------- reset pulse mid-stream at count=3 ----------------
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      s_in_data = W'(8'h60 + c);
      tick();
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    check("midrst_count_before", 32'(s_count), 32'd3);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(s_out_valid), 32'd0);
    check("midrst_count",     32'(s_count),     32'd0);
    check("midrst_in_ready",  32'(s_in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_out_ready = 1'b1;
    tick();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(s_out_valid), 32'd0);
      tick();
    end
    lone_beat("midrst_next", 8'h3C);

    // ---------------- FWD DEPTH=2 full, same-cycle ready ----------------
    f_out_ready = 1'b0;
    f_in_valid  = 1'b1;
    f_in_data   = 8'h21;
    @(negedge clk);
    check("fwd_in_ready0", 32'(f_in_ready), 32'd1);
    tick();
    f_in_data = 8'h22;
    @(negedge clk);
    check("fwd_in_ready1", 32'(f_in_ready), 32'd1);
    tick();
    f_in_data = 8'h23;
    @(negedge clk);
    check("fwd_full_in_ready", 32'(f_in_ready),  32'd0);
    check("fwd_full_count",    32'(f_count),     32'd2);
    check("fwd_full_out_data", 32'(f_out_data),  32'h21);
    f_out_ready = 1'b1;
    #1;
    check("fwd_comb_in_ready", 32'(f_in_ready), 32'd1);
    tick();
    f_in_valid = 1'b0;
    @(negedge clk);
    check("fwd_count_held", 32'(f_count),    32'd2);
    check("fwd_out_data_2", 32'(f_out_data), 32'h22);
    tick();
    @(negedge clk);
    check("fwd_out_data_3", 32'(f_out_data), 32'h23);
    check("fwd_count_1",    32'(f_count),    32'd1);
    tick();
    @(negedge clk);
    check("fwd_empty_valid", 32'(f_out_valid), 32'd0);
    check("fwd_empty_count", 32'(f_count),     32'd0);
    tick();

    // ---------------- random handshakes, scoreboard ----------------
    s_tx = 0; s_rx = 0; f_tx = 0; f_rx = 0;
    s_cur = W'($urandom);
    f_cur = W'($urandom);
    for (int c = 0; c < 6000 && (s_rx < NR || f_rx < NR); c++) begin
      s_in_valid  = (s_tx < NR) && ($urandom_range(3) != 0);
      s_in_data   = s_cur;
      s_out_ready = ($urandom_range(2) != 0);
      f_in_valid  = (f_tx < NR) && ($urandom_range(3) != 0);
      f_in_data   = f_cur;
      f_out_ready = ($urandom_range(2) != 0);
      s_acc = 1'b0;
      f_acc = 1'b0;
      @(negedge clk);
      ir0 = s_in_ready;
      s_out_ready = ~s_out_ready;
      #1;
      check("rnd_skid_ready_path", 32'(s_in_ready), 32'(ir0));
      s_out_ready = ~s_out_ready;
      #1;
      check("rnd_s_count", 32'(s_count), 32'(sq.size()));
      check("rnd_f_count", 32'(f_count), 32'(fq.size()));
      if (s_in_valid && s_in_ready) begin
        sq.push_back(s_cur);
        s_tx++;
        s_acc = 1'b1;
      end
      if (f_in_valid && f_in_ready) begin
        fq.push_back(f_cur);
        f_tx++;
        f_acc = 1'b1;
      end
      if (s_out_valid && s_out_ready) begin
        if (sq.size() == 0) check("rnd_s_spurious", 32'(s_out_valid), 32'd0);
        else check("rnd_s_data", 32'(s_out_data), 32'(sq.pop_front()));
        s_rx++;
      end
      if (f_out_valid && f_out_ready) begin
        if (fq.size() == 0) check("rnd_f_spurious", 32'(f_out_valid), 32'd0);
        else check("rnd_f_data", 32'(f_out_data), 32'(fq.pop_front()));
        f_rx++;
      end
      tick();
      if (s_acc) s_cur = W'($urandom);
      if (f_acc) f_cur = W'($urandom);
    end
    check("rnd_s_received", 32'(s_rx), 32'(NR));
    check("rnd_f_received", 32'(f_rx), 32'(NR));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_pipeline.md
ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload bits per beat.
REQ-002 SHALL have parameter DEPTH, default 4: number of register stages (legal range 1..16).
REQ-003 SHALL have parameter MODE, default MODE_SKID: stage type, MODE_FWD or MODE_SKID.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1: synchronous discard of all held beats.
REQ-007 SHALL have port in_valid, input, 1: upstream beat present.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port in_data, input, WIDTH: upstream payload.
REQ-010 SHALL have port out_valid, output, 1: beat presented downstream.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts.
REQ-012 SHALL have port out_data, output, WIDTH: downstream payload.
REQ-013 SHALL have port count, output, CW = $clog2(2*DEPTH+1): number of beats held.

Function
REQ-014 SHALL transfer on a port only when valid and ready are both high at the clock edge; payload is held stable while valid is high and ready is low.
REQ-015 SHALL chain DEPTH stages; beats SHALL leave in acceptance order, with no loss or duplication.
REQ-016 SHALL, in MODE_FWD, give each stage one entry; stage ready = ~stage_valid | next_ready, a combinational path from out_ready through to in_ready; capacity DEPTH.
REQ-017 SHALL, in MODE_SKID, give each stage a main and a skid entry; stage ready = ~skid_valid taken from a register, so there is no combinational path from out_ready to in_ready; capacity 2*DEPTH.
REQ-018 SHALL implement the MODE_SKID stage FSM: EMPTY -(push)-> BUSY; BUSY -(push, no pop)-> FULL; BUSY -(pop, no push)-> EMPTY; BUSY -(push and pop)-> BUSY with main replaced; FULL -(pop)-> BUSY with skid moved to main; all other cases hold state.
REQ-019 SHALL give 1-cycle latency per stage: a beat accepted at edge N on an empty pipeline raises out_valid after edge N+DEPTH-1 and is visible in cycle N+DEPTH.
REQ-020 SHALL sustain 1 beat/cycle in both modes when out_ready is held high.
REQ-021 SHALL update count each cycle by +1 on input transfer, -1 on output transfer, and by 0 when both occur; count SHALL never exceed capacity or go below 0.
REQ-022 SHALL, when flush is high at an edge, clear every valid and skid flag and set count to 0; in that cycle in_ready SHALL be 0, and any output handshake completed in that cycle stands.
REQ-023 SHALL give flush priority over a simultaneous push or pop in every stage.
REQ-024 SHALL write data registers only on push; data is don't-care while the matching valid is low.

Reset
REQ-025 SHALL, while rst is high, force out_valid=0, count=0, all stage FSMs to EMPTY, and all data registers to 0, asynchronously.
REQ-026 SHALL drive in_ready=0 while rst is high, and in the first cycle after release drive in_ready=1.
REQ-027 SHALL discard in-flight beats when rst asserts mid-operation; no beat is emitted after reset release until a new input transfer.

Structure
REQ-028 SHALL place typedef enum pipe_mode_e {MODE_FWD, MODE_SKID} and the stage-state enum {EMPTY, BUSY, FULL} in package elastic_pkg.
REQ-029 SHALL instantiate one sub-module, elastic_stage (WIDTH, MODE), DEPTH times with a generate loop; count logic lives in the top level.

Verification
REQ-030 SHALL cover: MODE_SKID, DEPTH=4, out_ready=1, push 0x1..0x8 back-to-back -> 0x1 appears at cycle 4, then one beat per cycle in order, count holds 4.
REQ-031 SHALL cover: MODE_SKID, DEPTH=4, out_ready=0, in_valid=1 continuously -> exactly 8 beats accepted, in_ready=0 afterward, count=8; raising out_ready drains 8 beats in order.
REQ-032 SHALL cover: MODE_FWD, DEPTH=2, full with out_ready=0, then out_ready=1 with in_valid=1 -> in_ready=1 in the same cycle, count stays 2.
REQ-033 SHALL cover: count=5 in MODE_SKID, flush=1 with in_valid=1 -> in_ready=0, then count=0 and out_valid=0 next cycle; the next push 0xA5 emerges after 4 cycles.
REQ-034 SHALL cover: rst pulse mid-stream at count=3 -> out_valid=0 and count=0 immediately; no stale beats after release.
REQ-035 SHALL cover: random valid/ready, 10k beats, both modes, DEPTH in {1,3,16} -> scoreboard shows order and data exact, and in_ready never depends combinationally on out_ready in MODE_SKID.
